debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised N-channel debouncer; successor to the single-channel reset-button debouncer.
- Synchronises each raw asynchronous input, then requires it to be stable for STABLE_CNT sample strobes before the debounced level changes.
- Emits per-channel one-cycle rise/fall pulses, e.g. the PC-increment strobe, plus an aggregate change flag.
- Sits between board pushbuttons/switches and the control datapath.

Parameters:
N_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
STABLE_CNT, 4, consecutive qualifying strobes required to accept a new level (>=1)
CNT_W, 16, per-channel counter width; must satisfy 2^CNT_W > STABLE_CNT
RESET_LEVEL, 0, value loaded into synchronisers and o_level on reset (same for all channels)

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_tick  in  1  sample strobe; tie to 1 to sample every clock
i_in  in  N_CH  raw bouncing inputs, asynchronous to i_clk
o_level  out  N_CH  debounced level per channel
o_rise  out  N_CH  one-cycle pulse when o_level[c] goes 0->1
o_fall  out  N_CH  one-cycle pulse when o_level[c] goes 1->0
o_any_change  out  1  OR of all o_rise and o_fall bits, same cycle

Behaviour:
- Reset (i_reset=0, asynchronous):
  - all synchroniser flops and o_level = RESET_LEVEL;
  - counters = 0;
  - o_rise, o_fall and o_any_change = 0.
  - Release causes no spurious edge pulse while i_in equals RESET_LEVEL.
- Synchroniser: SYNC_STAGES-flop chain per channel, clocked every edge and independent of i_tick. s[c] is the last stage.
- Per-channel counter, evaluated only at edges where i_tick=1:
  - s[c]==o_level[c]: counter <- 0.
  - s[c]!=o_level[c] and counter==STABLE_CNT-1: o_level[c] <- s[c]; counter <- 0.
  - s[c]!=o_level[c] otherwise: counter <- counter+1.
- i_tick=0: counters and o_level hold; pulses deassert.
- Pulses:
  - o_rise[c] and o_fall[c] are registered, high for exactly the one cycle after the edge that updates o_level[c]; they coincide with the new o_level value.
  - At most one of o_rise[c] / o_fall[c] is high in any cycle.
- Latency with i_tick=1: the input is first captured at edge E0 and then held stable. o_level updates at edge E0+SYNC_STAGES+STABLE_CNT-1 (defaults: E0+5).
- Bounce rejection: any return of s[c] to o_level[c] before acceptance clears the counter. The full STABLE_CNT must then be re-accumulated; there is no partial credit.
- Channels are fully independent. Simultaneous acceptance on several channels produces simultaneous pulses, and o_any_change is high once, for that single cycle.
- Counter never exceeds STABLE_CNT-1; no wrap-around is possible.
- Reset mid-count: the counter is discarded and no pulse is generated; o_level returns to RESET_LEVEL.
- An input pulse narrower than one clock may be missed by the synchroniser; this is acceptable.

Test Plan:
1. Clean step, defaults, 10 ns clock, i_tick=1: i_in[0] 0->1 captured at edge E0 and held.
   -> o_level[0]=1 from edge E0+5.
   -> o_rise[0]=1 for exactly one cycle after E0+5.
   -> o_any_change=1 in that same cycle.
   -> other channels stay 0.
2. Bounce: i_in[1] toggles 1,0,1,0 with 20 ns half-periods, then holds 1.
   -> no o_rise[1] during the bounce.
   -> a single o_rise[1] at 5 edges after the final stable capture.
3. Fall plus prescale: i_tick high one cycle in four, o_level[2]=1, i_in[2] -> 0 held.
   -> o_fall[2] pulses exactly once, after 4 qualifying ticks post-synchroniser.
   -> o_level[2] stays 1 throughout the intervening i_tick=0 cycles.
4. Simultaneous events: i_in = 4'b1111 in one cycle from 4'b0000.
   -> o_rise = 4'b1111 in the same single cycle.
   -> o_any_change high for one cycle only.
5. Reset mid-count: i_in[3]=1 for 3 stable edges, then i_reset=0 asynchronously between clock edges.
   -> outputs clear immediately with no clock edge.
   -> after release with i_in[3] still 1, a full 5-edge qualification occurs before o_rise[3].
6. Parameter sweep: N_CH=1, SYNC_STAGES=3, STABLE_CNT=1, RESET_LEVEL=1.
   -> post-reset o_level=1 with no pulse.
   -> a 0 step captured at E0 gives o_fall at E0+3.

Source files
------------

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel input debouncer with synchroniser, tick-qualified
// stability counters, per-channel rise/fall pulses and an aggregate change flag.
module debounce_multi #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 4,
  parameter int CNT_W       = 16,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_tick,
  input  logic [N_CH-1:0] i_in,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic            o_any_change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q [N_CH];
  logic [CNT_W-1:0]       cnt_q  [N_CH];
  logic [N_CH-1:0]        s;

  // Synchroniser runs every clock, independent of the sample strobe.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int c = 0; c < N_CH; c++) begin
        sync_q[c] <= {SYNC_STAGES{RESET_LEVEL}};
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], i_in[c]};
      end
    end
  end

  always_comb begin
    s = '0;
    for (int c = 0; c < N_CH; c++) begin
      s[c] = sync_q[c][SYNC_STAGES-1];
    end
  end

  // Any sample matching the current level clears the count: no partial credit for bounces.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c] <= '0;
      end
      o_level <= {N_CH{RESET_LEVEL}};
      o_rise  <= '0;
      o_fall  <= '0;
    end else begin
      o_rise <= '0;
      o_fall <= '0;
      if (i_tick) begin
        for (int c = 0; c < N_CH; c++) begin
          if (s[c] == o_level[c]) begin
            cnt_q[c] <= '0;
          end else if (cnt_q[c] == CNT_LAST) begin
            cnt_q[c]   <= '0;
            o_level[c] <= s[c];
            o_rise[c]  <= s[c];
            o_fall[c]  <= ~s[c];
          end else begin
            cnt_q[c] <= cnt_q[c] + CNT_ONE;
          end
        end
      end
    end
  end

  assign o_any_change = |{o_rise, o_fall};

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - directed self-checking bench for debounce_multi
// (default instance plus a one-channel, three-stage, single-strobe variant).
module tb_debounce_multi;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_tick;
  logic [3:0] i_in;
  logic [3:0] o_level;
  logic [3:0] o_rise;
  logic [3:0] o_fall;
  logic       o_any_change;

  logic       p_reset;
  logic       p_tick;
  logic [0:0] p_in;
  logic [0:0] p_level;
  logic [0:0] p_rise;
  logic [0:0] p_fall;
  logic       p_any;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  debounce_multi #(
    .N_CH(4), .SYNC_STAGES(2), .STABLE_CNT(4), .CNT_W(16), .RESET_LEVEL(1'b0)
  ) u_dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_in(i_in),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall), .o_any_change(o_any_change)
  );

  debounce_multi #(
    .N_CH(1), .SYNC_STAGES(3), .STABLE_CNT(1), .CNT_W(4), .RESET_LEVEL(1'b1)
  ) u_p (
    .i_clk(i_clk), .i_reset(p_reset), .i_tick(p_tick), .i_in(p_in),
    .o_level(p_level), .o_rise(p_rise), .o_fall(p_fall), .o_any_change(p_any)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    i_reset = 1'b0;
    i_tick  = 1'b1;
    i_in    = 4'b0000;
    p_reset = 1'b0;
    p_tick  = 1'b1;
    p_in    = 1'b1;
    step();
    step();
    chk("rst_level", o_level, 8'h0);
    chk("rst_rise", o_rise, 8'h0);
    chk("rst_fall", o_fall, 8'h0);
    chk("rst_any", o_any_change, 8'h0);
    chk("p_rst_level", p_level, 8'h1);
    chk("p_rst_fall", p_fall, 8'h0);

    i_reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_pulse", {o_rise, o_fall}, 8'h0);
      chk("post_rst_level", o_level, 8'h0);
    end

    // Clean rising step on channel 0
    i_in = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_wait_level", o_level, 8'h0);
      chk("t1_wait_rise", o_rise, 8'h0);
    end
    step();
    chk("t1_level", o_level, 8'h1);
    chk("t1_rise", o_rise, 8'h1);
    chk("t1_any", o_any_change, 8'h1);
    chk("t1_fall", o_fall, 8'h0);
    step();
    chk("t1_rise_gone", o_rise, 8'h0);
    chk("t1_any_gone", o_any_change, 8'h0);
    chk("t1_level_hold", o_level, 8'h1);

    // Bounce on channel 1, two clocks per half-period
    for (int b = 0; b < 4; b++) begin
      i_in[1] = (b % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        step();
        chk("t2_bounce_rise", o_rise[1], 8'h0);
        chk("t2_bounce_level", o_level[1], 8'h0);
      end
    end
    i_in[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_wait_rise", o_rise, 8'h0);
      chk("t2_wait_level", o_level, 8'h1);
    end
    step();
    chk("t2_rise", o_rise, 8'h2);
    chk("t2_level", o_level, 8'h3);
    chk("t2_any", o_any_change, 8'h1);
    step();
    chk("t2_rise_gone", o_rise, 8'h0);

    // Fall on channel 2 with a one-in-four sample strobe
    i_in[2] = 1'b1;
    repeat (8) step();
    chk("t3_pre_level", o_level, 8'h7);
    i_in[2] = 1'b0;
    for (int k = 0; k < 17; k++) begin
      i_tick = (k % 4 == 3);
      step();
      if (k < 15) begin
        chk("t3_hold_level", o_level, 8'h7);
        chk("t3_hold_fall", o_fall, 8'h0);
      end else if (k == 15) begin
        chk("t3_level", o_level, 8'h3);
        chk("t3_fall", o_fall, 8'h4);
        chk("t3_rise", o_rise, 8'h0);
        chk("t3_any", o_any_change, 8'h1);
      end else begin
        chk("t3_fall_gone", o_fall, 8'h0);
        chk("t3_any_gone", o_any_change, 8'h0);
      end
    end
    i_tick = 1'b1;

    // All four channels rise together
    i_in = 4'b0000;
    repeat (8) step();
    chk("t4_pre_level", o_level, 8'h0);
    i_in = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_wait_rise", o_rise, 8'h0);
      chk("t4_wait_any", o_any_change, 8'h0);
    end
    step();
    chk("t4_rise", o_rise, 8'hF);
    chk("t4_any", o_any_change, 8'h1);
    chk("t4_fall", o_fall, 8'h0);
    chk("t4_level", o_level, 8'hF);
    step();
    chk("t4_any_gone", o_any_change, 8'h0);
    chk("t4_rise_gone", o_rise, 8'h0);

    // Asynchronous reset while channel 3 is mid-count
    i_in = 4'b0111;
    repeat (8) step();
    chk("t5_pre_level", o_level, 8'h7);
    i_in = 4'b1111;
    repeat (3) step();
    chk("t5_mid_level", o_level, 8'h7);
    #2 i_reset = 1'b0;
    #1;
    chk("t5_async_level", o_level, 8'h0);
    chk("t5_async_rise", o_rise, 8'h0);
    chk("t5_async_fall", o_fall, 8'h0);
    chk("t5_async_any", o_any_change, 8'h0);
    step();
    chk("t5_in_rst_level", o_level, 8'h0);
    i_reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_requal_level", o_level, 8'h0);
      chk("t5_requal_rise", o_rise, 8'h0);
    end
    step();
    chk("t5_rise", o_rise, 8'hF);
    chk("t5_level", o_level, 8'hF);

    // Variant: one channel, three sync stages, single strobe, reset level 1
    p_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_post_rst_level", p_level, 8'h1);
      chk("t6_post_rst_pulse", {p_rise, p_fall, p_any}, 8'h0);
    end
    p_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_wait_level", p_level, 8'h1);
      chk("t6_wait_fall", p_fall, 8'h0);
    end
    step();
    chk("t6_level", p_level, 8'h0);
    chk("t6_fall", p_fall, 8'h1);
    chk("t6_any", p_any, 8'h1);
    chk("t6_rise", p_rise, 8'h0);
    step();
    chk("t6_fall_gone", p_fall, 8'h0);
    chk("t6_any_gone", p_any, 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
